// File: rtl/find_stars_pkg.sv
// Shared constants and state encoding for the star-map scanner.
package find_stars_pkg;
  localparam int GRID_W   = 6;
  localparam int GRID_H   = 8;
  localparam int ADDR_W   = 6;
  localparam int COORD_W  = 3;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BG_COLOUR = 3'b000;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_READ    = 3'd1;
  localparam logic [2:0] ST_COMPARE = 3'd2;
  localparam logic [2:0] ST_EMIT    = 3'd3;
  localparam logic [2:0] ST_ADVANCE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    READ    = ST_READ,
    COMPARE = ST_COMPARE,
    EMIT    = ST_EMIT,
    ADVANCE = ST_ADVANCE,
    DONE    = ST_DONE
  } state_t;
endpackage

// File: rtl/star_scanner_address_translator.sv
// Maps a 6-wide grid coordinate to a linear ROM address: y*4 + y*2 + x.
module address_translator (
  input  logic [2:0] x,
  input  logic [2:0] y,
  output logic [5:0] mem_address
);
  assign mem_address = {1'b0, y, 2'b00} + {2'b00, y, 1'b0} + {3'b000, x};
endmodule

// File: rtl/star_scanner.sv
// Raster-scans the star-map ROM and hands every non-background cell to the
// plotter as an (x, y, colour) record over valid/ready, counting accepted stars.
module star_scanner #(
  parameter int                 GRID_W    = find_stars_pkg::GRID_W,
  parameter int                 GRID_H    = find_stars_pkg::GRID_H,
  parameter logic [2:0]         BG_COLOUR = find_stars_pkg::BG_COLOUR
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  output logic [5:0] mem_address,
  input  logic [2:0] mem_q,
  output logic       star_valid,
  input  logic       star_ready,
  output logic [2:0] star_x,
  output logic [2:0] star_y,
  output logic [2:0] star_colour,
  output logic [5:0] star_count,
  output logic       busy,
  output logic       done
);
  import find_stars_pkg::*;

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

  state_t                state_q, state_d;
  logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0]    star_x_q, star_x_d, star_y_q, star_y_d;
  logic [COLOUR_W-1:0]   star_colour_q, star_colour_d;
  logic [ADDR_W-1:0]     star_count_q, star_count_d;

  // Address comes straight from the cell registers so it is stable across
  // READ, COMPARE, EMIT and ADVANCE of each cell.
  address_translator u_addr (
    .x           (x_q),
    .y           (y_q),
    .mem_address (mem_address)
  );

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    star_x_d      = star_x_q;
    star_y_d      = star_y_q;
    star_colour_d = star_colour_q;
    star_count_d  = star_count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d          = '0;
          y_d          = '0;
          star_count_d = '0;
          state_d      = READ;
        end
      end
      READ:    state_d = COMPARE;
      COMPARE: begin
        if (mem_q != BG_COLOUR) begin
          star_x_d      = x_q;
          star_y_d      = y_q;
          star_colour_d = mem_q;
          state_d       = EMIT;
        end else begin
          state_d = ADVANCE;
        end
      end
      EMIT: begin
        if (star_ready) begin
          star_count_d = star_count_q + 6'd1;
          state_d      = ADVANCE;
        end
      end
      ADVANCE: begin
        if (x_q < X_MAX) begin
          x_d     = x_q + 3'd1;
          state_d = READ;
        end else if (y_q < Y_MAX) begin
          x_d     = '0;
          y_d     = y_q + 3'd1;
          state_d = READ;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      star_x_q      <= '0;
      star_y_q      <= '0;
      star_colour_q <= '0;
      star_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      star_x_q      <= star_x_d;
      star_y_q      <= star_y_d;
      star_colour_q <= star_colour_d;
      star_count_q  <= star_count_d;
    end
  end

  assign star_valid  = (state_q == EMIT);
  assign busy        = (state_q == READ) || (state_q == COMPARE) ||
                       (state_q == EMIT) || (state_q == ADVANCE);
  assign done        = (state_q == DONE);
  assign star_x      = star_x_q;
  assign star_y      = star_y_q;
  assign star_colour = star_colour_q;
  assign star_count  = star_count_q;
endmodule
